// File: rtl/multdiv32_if.sv
// Handshake and result bus between the pipeline and the multiply/divide unit.
interface multdiv32_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, read_data_1, read_data_2,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, read_data_1, read_data_2,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/multdiv32.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Optional MULTDIV_FAST_MULT_EN: multiplies use a single-cycle multiplier and skip RUN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | 32 shift-add / shift-subtract iterations
// FIX   | sign correction, hi/lo written
// DONE  | one-cycle done pulse, may accept a new start
module multdiv32 (
  input  logic clock,
  input  logic reset,
  multdiv32_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state, state_next;
  logic [5:0]  count;
  logic [63:0] acc;
  logic [31:0] mag_a, mag_b;
  logic        sign_a, sign_res, is_div, dz_flag;
  logic [31:0] hi_q, lo_q;

  logic        accept, arith_op, op_signed, sa, sb;
  logic [32:0] add_sum, shifted, sub_diff;
  logic [63:0] mul_next, div_next, prod;

  assign accept    = bus.start && (state == IDLE || state == DONE);
  assign arith_op  = (bus.op[2] == 1'b0);
  assign op_signed = ~bus.op[0];
  assign sa        = op_signed & bus.read_data_1[31];
  assign sb        = op_signed & bus.read_data_2[31];

  // Multiply: acc = {partial, multiplier}; add multiplicand when the low bit is set, then shift right.
  assign add_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
  assign mul_next = {add_sum, acc[31:1]};

  // Divide: acc = {remainder, dividend/quotient}; restoring subtract of the divisor.
  assign shifted  = {acc[63:32], acc[31]};
  assign sub_diff = shifted - {1'b0, mag_b};
  assign div_next = sub_diff[32] ? {shifted[31:0], acc[30:0], 1'b0}
                                 : {sub_diff[31:0], acc[30:0], 1'b1};

`ifdef MULTDIV_FAST_MULT_EN
  assign prod = 64'(mag_a) * 64'(mag_b);
`else
  assign prod = acc;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (bus.start) begin
          unique case (bus.op)
`ifdef MULTDIV_FAST_MULT_EN
            OP_MULT, OP_MULTU: state_next = FIX;
`else
            OP_MULT, OP_MULTU: state_next = RUN;
`endif
            OP_DIV, OP_DIVU:   state_next = RUN;
            default:           state_next = IDLE;
          endcase
        end
      end
      RUN:     state_next = (count == 6'd31) ? FIX : RUN;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state == RUN) || (state == FIX);
    bus.done     = (state == DONE);
    bus.div_zero = (state == DONE) && dz_flag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      acc      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      sign_a   <= 1'b0;
      sign_res <= 1'b0;
      is_div   <= 1'b0;
      dz_flag  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (accept) begin
      if (arith_op) begin
        count    <= '0;
        mag_a    <= sa ? -bus.read_data_1 : bus.read_data_1;
        mag_b    <= sb ? -bus.read_data_2 : bus.read_data_2;
        sign_a   <= sa;
        sign_res <= sa ^ sb;
        is_div   <= bus.op[1];
        dz_flag  <= bus.op[1] && (bus.read_data_2 == 32'd0);
        acc      <= bus.op[1] ? {32'd0, (sa ? -bus.read_data_1 : bus.read_data_1)}
                              : {32'd0, (sb ? -bus.read_data_2 : bus.read_data_2)};
      end else if (bus.op == OP_MTHI) begin
        hi_q <= bus.read_data_1;
      end else if (bus.op == OP_MTLO) begin
        lo_q <= bus.read_data_1;
      end
    end else if (state == RUN) begin
      acc   <= is_div ? div_next : mul_next;
      count <= count + 6'd1;
    end else if (state == FIX) begin
      if (is_div) begin
        // A zero divisor leaves quotient all ones and remainder = |rs|, so hi restores rs.
        lo_q <= dz_flag ? 32'hFFFF_FFFF : (sign_res ? -acc[31:0] : acc[31:0]);
        hi_q <= sign_a ? -acc[63:32] : acc[63:32];
      end else begin
        {hi_q, lo_q} <= sign_res ? -prod : prod;
      end
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_multdiv32.sv
// Self-checking bench for multdiv32: directed table, corner sequences, random ops vs. arithmetic model.
module tb_multdiv32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  multdiv32_if mif ();
  multdiv32 dut (.clock(clock), .reset(reset), .bus(mif.slave));

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    rdz = 1'b0;
    rhi = '0;
    rlo = '0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); rhi = p[63:32]; rlo = p[31:0]; end
      3'd1: begin p = 64'(a) * 64'(b); rhi = p[63:32]; rlo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          rdz = 1'b1; rlo = 32'hFFFF_FFFF; rhi = a;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb;
          rlo = q[31:0]; rhi = r[31:0];
        end else begin
          rlo = a / b; rhi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op);
`ifdef MULTDIV_FAST_MULT_EN
    if (op == 3'd0 || op == 3'd1) return 2;
`endif
    return 34;
  endfunction

  // Called on a negedge; returns on the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    int lat, busy_n, el;
    mif.start = 1'b1; mif.op = op; mif.read_data_1 = a; mif.read_data_2 = b;
    @(negedge clock);
    mif.start = 1'b0;
    lat = 1; busy_n = 0;
    while (lat <= 60 && !mif.done) begin
      if (mif.busy) busy_n++;
      @(negedge clock);
      lat++;
    end
    el = exp_latency(op);
    chk({tag, " latency"}, lat, el);
    chk({tag, " busy_cycles"}, busy_n, el - 1);
    chk({tag, " hi"}, mif.hi, ehi);
    chk({tag, " lo"}, mif.lo, elo);
    chk({tag, " div_zero"}, 32'(mif.div_zero), 32'(edz));
    chk({tag, " busy_in_done"}, 32'(mif.busy), 32'd0);
  endtask

  initial begin
    int cyc, first_done, n_done;
    logic [31:0] rhi, rlo;
    logic rdz;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    tbl[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
    tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3]  = '{3'd3, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    tbl[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[5]  = '{3'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    tbl[6]  = '{3'd3, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0};
    tbl[7]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    tbl[8]  = '{3'd1, 32'd0,         32'h0001_2345, 32'd0,         32'd0,         1'b0};
    tbl[9]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    tbl[10] = '{3'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};

    mif.start = 1'b0; mif.op = 3'd0; mif.read_data_1 = '0; mif.read_data_2 = '0;
    reset = 1'b1;
    mif.start = 1'b1; mif.op = 3'd4; mif.read_data_1 = 32'h5555_5555;
    repeat (3) @(negedge clock);
    chk("reset busy", 32'(mif.busy), 0);
    chk("reset done", 32'(mif.done), 0);
    chk("reset div_zero", 32'(mif.div_zero), 0);
    chk("reset hi", mif.hi, 0);
    chk("reset lo", mif.lo, 0);
    mif.start = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 11; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo, tbl[i].edz);
    @(negedge clock);

    // MTHI then MTLO on consecutive cycles
    mif.start = 1'b1; mif.op = 3'd4; mif.read_data_1 = 32'h0000_1234;
    @(negedge clock);
    chk("mthi busy", 32'(mif.busy), 0);
    chk("mthi done", 32'(mif.done), 0);
    chk("mthi hi", mif.hi, 32'h0000_1234);
    mif.op = 3'd5; mif.read_data_1 = 32'hABCD_0000;
    @(negedge clock);
    mif.start = 1'b0;
    chk("mtlo busy", 32'(mif.busy), 0);
    chk("mtlo hi", mif.hi, 32'h0000_1234);
    chk("mtlo lo", mif.lo, 32'hABCD_0000);

    // No-op codes leave everything untouched
    mif.start = 1'b1; mif.op = 3'd6; mif.read_data_1 = 32'hDEAD_BEEF; mif.read_data_2 = 32'd1;
    @(negedge clock);
    mif.op = 3'd7;
    @(negedge clock);
    mif.start = 1'b0;
    @(negedge clock);
    chk("noop busy", 32'(mif.busy), 0);
    chk("noop done", 32'(mif.done), 0);
    chk("noop hi", mif.hi, 32'h0000_1234);
    chk("noop lo", mif.lo, 32'hABCD_0000);

    // Start while busy is ignored
    mif.start = 1'b1; mif.op = 3'd2; mif.read_data_1 = 32'd100; mif.read_data_2 = 32'd7;
    @(negedge clock);
    mif.start = 1'b0;
    cyc = 1; first_done = 0; n_done = 0;
    while (cyc < 70) begin
      if (cyc == 5) begin
        mif.start = 1'b1; mif.op = 3'd3; mif.read_data_1 = 32'd7; mif.read_data_2 = 32'd2;
      end else begin
        mif.start = 1'b0;
      end
      if (mif.done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = cyc;
          chk("ignore hi", mif.hi, 32'd2);
          chk("ignore lo", mif.lo, 32'd14);
        end
      end
      @(negedge clock);
      cyc++;
    end
    chk("ignore done_cycle", first_done, 34);
    chk("ignore done_count", n_done, 1);

    // Reset in cycle 10 of a DIV aborts it
    mif.start = 1'b1; mif.op = 3'd2; mif.read_data_1 = 32'd1000; mif.read_data_2 = 32'd3;
    @(negedge clock);
    mif.start = 1'b0;
    repeat (9) @(negedge clock);
    chk("abort busy_before", 32'(mif.busy), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort busy", 32'(mif.busy), 0);
    chk("abort hi", mif.hi, 0);
    chk("abort lo", mif.lo, 0);
    n_done = 0;
    for (int k = 0; k < 50; k++) begin
      if (mif.done || mif.busy) n_done++;
      @(negedge clock);
    end
    chk("abort no_activity", n_done, 0);

    // Random operations against the arithmetic model
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      ref_model(rop, ra, rb, rhi, rlo, rdz);
      run_op($sformatf("rnd%0d op%0d %h/%h", i, rop, ra, rb), rop, ra, rb, rhi, rlo, rdz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
